nr2w_req_stage: RTL and testbench

- Upstream request-staging block that feeds the nR2W/1R1W multiport memory core (2 write ports, NUMRDPT read ports).
- Accepts one client command bundle per cycle (up to 2 writes plus NUMRDPT reads) over a valid/ready handshake and buffers bundles in a FIFO.
- Issues buffered bundles to the core only while the core's ready is high, including during post-reset init.
- Sanitises every bundle before buffering: drops out-of-range operations and resolves same-address double writes. Drop events are counted for debug.

---
 rtl/nr2w_req_stage.sv | 156 +++++++++++++++
 tb/tb_nr2w_req_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr2w_req_stage.sv
// nr2w_req_stage: request staging in front of the nR2W/1R1W multiport core.
// Client bundles (2 writes + NUMRDPT reads) are sanitised, buffered in a
// small FIFO and issued to the core one per cycle whenever the core is ready.
module nr2w_req_stage #(
  parameter int WIDTH   = 32,
  parameter int NUMRDPT = 2,
  parameter int NUMADDR = 8192,
  parameter int BITADDR = 13,
  parameter int FIFODEP = 4,
  parameter int BITFDEP = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cl_vld,
  output logic                       cl_rdy,
  input  logic [1:0]                 cl_write,
  input  logic [2*BITADDR-1:0]       cl_wr_adr,
  input  logic [2*WIDTH-1:0]         cl_din,
  input  logic [NUMRDPT-1:0]         cl_read,
  input  logic [NUMRDPT*BITADDR-1:0] cl_rd_adr,
  input  logic                       ready,
  output logic [1:0]                 write,
  output logic [2*BITADDR-1:0]       wr_adr,
  output logic [2*WIDTH-1:0]         din,
  output logic [NUMRDPT-1:0]         read,
  output logic [NUMRDPT*BITADDR-1:0] rd_adr,
  output logic [BITFDEP:0]           fifo_cnt,
  output logic [15:0]                oor_cnt,
  output logic [15:0]                wcol_cnt
);

  localparam logic [BITFDEP:0]   DEPTH_C = (BITFDEP+1)'(FIFODEP);
  localparam logic [BITFDEP:0]   ONE_C   = (BITFDEP+1)'(1);
  localparam logic [BITFDEP-1:0] PONE_C  = BITFDEP'(1);
  localparam int unsigned        NADDR   = NUMADDR;

  // Address legality check against the core's populated address range.
  function automatic logic in_range(input logic [BITADDR-1:0] adr);
    return 32'(adr) < NADDR;
  endfunction

  // 16-bit saturating accumulate for the debug counters.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0]         wr_en_p0;
  logic [NUMRDPT-1:0] rd_en_p0;
  logic [7:0]         oor_n_p0;
  logic               wcol_p0;
  logic               vld_p0;
  logic               vld_p1;
  logic               empty;

  logic [BITFDEP-1:0] wr_ptr;
  logic [BITFDEP-1:0] rd_ptr;

  logic [1:0]                 mem_write  [FIFODEP];
  logic [2*BITADDR-1:0]       mem_wr_adr [FIFODEP];
  logic [2*WIDTH-1:0]         mem_din    [FIFODEP];
  logic [NUMRDPT-1:0]         mem_read   [FIFODEP];
  logic [NUMRDPT*BITADDR-1:0] mem_rd_adr [FIFODEP];

  // Ready is held low through reset so nothing is accepted while clearing.
  assign cl_rdy = rst & (fifo_cnt != DEPTH_C);
  assign empty  = (fifo_cnt == '0);
  assign vld_p0 = cl_vld & cl_rdy;
  assign vld_p1 = ready & ~empty;

  // Sanitise the incoming bundle: drop out-of-range ops, then let port 1 win a same-address double write.
  always_comb begin
    wr_en_p0 = cl_write;
    rd_en_p0 = cl_read;
    oor_n_p0 = 8'd0;
    wcol_p0  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (cl_write[p] && !in_range(cl_wr_adr[p*BITADDR +: BITADDR])) begin
        wr_en_p0[p] = 1'b0;
        oor_n_p0    = oor_n_p0 + 8'd1;
      end
    end
    for (int r = 0; r < NUMRDPT; r++) begin
      if (cl_read[r] && !in_range(cl_rd_adr[r*BITADDR +: BITADDR])) begin
        rd_en_p0[r] = 1'b0;
        oor_n_p0    = oor_n_p0 + 8'd1;
      end
    end
    if (wr_en_p0[0] && wr_en_p0[1] &&
        (cl_wr_adr[0 +: BITADDR] == cl_wr_adr[BITADDR +: BITADDR])) begin
      wr_en_p0[0] = 1'b0;
      wcol_p0     = 1'b1;
    end
  end

  // Bundle storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mem_write[wr_ptr]  <= wr_en_p0;
      mem_wr_adr[wr_ptr] <= cl_wr_adr;
      mem_din[wr_ptr]    <= cl_din;
      mem_read[wr_ptr]   <= rd_en_p0;
      mem_rd_adr[wr_ptr] <= cl_rd_adr;
    end
  end

  // FIFO pointers and occupancy; full/empty come from the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + PONE_C;
      if (vld_p1) rd_ptr <= rd_ptr + PONE_C;
      case ({vld_p0, vld_p1})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Drop counters, advanced only for accepted bundles and saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_cnt  <= '0;
      wcol_cnt <= '0;
    end else if (vld_p0) begin
      oor_cnt <= sat_add16(oor_cnt, oor_n_p0);
      if (wcol_p0) wcol_cnt <= sat_add16(wcol_cnt, 8'd1);
    end
  end

  // Core-facing registers: load the head on pop, otherwise idle the enables and keep addresses/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write  <= '0;
      read   <= '0;
      wr_adr <= '0;
      din    <= '0;
      rd_adr <= '0;
    end else if (vld_p1) begin
      write  <= mem_write[rd_ptr];
      read   <= mem_read[rd_ptr];
      wr_adr <= mem_wr_adr[rd_ptr];
      din    <= mem_din[rd_ptr];
      rd_adr <= mem_rd_adr[rd_ptr];
    end else begin
      write <= '0;
      read  <= '0;
    end
  end

endmodule

// File: tb/tb_nr2w_req_stage.sv
// Bench for nr2w_req_stage: queue-based reference model with a scoreboard
// that checks every issued cycle, plus directed scenarios and random traffic.
module tb_nr2w_req_stage;

  localparam int W  = 32;
  localparam int NR = 2;
  localparam int NA = 8192;
  localparam int BA = 14;
  localparam int FD = 4;
  localparam int BF = 2;

  typedef struct packed {
    logic [1:0]       w;
    logic [2*BA-1:0]  wa;
    logic [2*W-1:0]   d;
    logic [NR-1:0]    r;
    logic [NR*BA-1:0] ra;
  } bundle_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cl_vld;
  logic             cl_rdy;
  logic [1:0]       cl_write;
  logic [2*BA-1:0]  cl_wr_adr;
  logic [2*W-1:0]   cl_din;
  logic [NR-1:0]    cl_read;
  logic [NR*BA-1:0] cl_rd_adr;
  logic             ready;
  logic [1:0]       write;
  logic [2*BA-1:0]  wr_adr;
  logic [2*W-1:0]   din;
  logic [NR-1:0]    read;
  logic [NR*BA-1:0] rd_adr;
  logic [BF:0]      fifo_cnt;
  logic [15:0]      oor_cnt;
  logic [15:0]      wcol_cnt;

  int checks = 0;
  int errors = 0;

  nr2w_req_stage #(
    .WIDTH(W), .NUMRDPT(NR), .NUMADDR(NA), .BITADDR(BA), .FIFODEP(FD), .BITFDEP(BF)
  ) dut (
    .clk(clk), .rst(rst), .cl_vld(cl_vld), .cl_rdy(cl_rdy),
    .cl_write(cl_write), .cl_wr_adr(cl_wr_adr), .cl_din(cl_din),
    .cl_read(cl_read), .cl_rd_adr(cl_rd_adr), .ready(ready),
    .write(write), .wr_adr(wr_adr), .din(din), .read(read), .rd_adr(rd_adr),
    .fifo_cnt(fifo_cnt), .oor_cnt(oor_cnt), .wcol_cnt(wcol_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference sanitiser: each illegal op is dropped and counted; a legal double write to one address keeps port 1.
  function automatic bundle_t sanitise(input bundle_t b, output int n_oor, output int n_col);
    bundle_t s;
    s = b;
    n_oor = 0;
    n_col = 0;
    for (int p = 0; p < 2; p++)
      if (b.w[p] && int'(b.wa[p*BA +: BA]) >= NA) begin s.w[p] = 1'b0; n_oor++; end
    for (int r = 0; r < NR; r++)
      if (b.r[r] && int'(b.ra[r*BA +: BA]) >= NA) begin s.r[r] = 1'b0; n_oor++; end
    if (s.w == 2'b11 && b.wa[0 +: BA] == b.wa[BA +: BA]) begin s.w[0] = 1'b0; n_col = 1; end
    return s;
  endfunction

  // Reference model state
  bundle_t q[$];
  bundle_t last = '0;
  int oor_m = 0;
  int wcol_m = 0;

  always @(negedge rst) begin
    q.delete();
    last   = '0;
    oor_m  = 0;
    wcol_m = 0;
  end

  // Scoreboard: model the accept/issue at each edge, then compare all outputs just after it.
  always @(posedge clk) begin
    bundle_t cur;
    bundle_t s;
    logic [1:0] ew;
    logic [NR-1:0] er;
    int no;
    int nc;
    int sz;
    if (rst === 1'b1) begin
      sz = q.size();
      ew = '0;
      er = '0;
      if (ready && sz > 0) begin
        s = q.pop_front();
        ew = s.w;
        er = s.r;
        last = s;
      end
      if (cl_vld && sz < FD) begin
        cur = {cl_write, cl_wr_adr, cl_din, cl_read, cl_rd_adr};
        s = sanitise(cur, no, nc);
        q.push_back(s);
        oor_m  = (oor_m + no > 65535) ? 65535 : oor_m + no;
        wcol_m = (wcol_m + nc > 65535) ? 65535 : wcol_m + nc;
      end
      #1;
      chk("sb_write", 64'(write), 64'(ew));
      chk("sb_read", 64'(read), 64'(er));
      chk("sb_wr_adr", 64'(wr_adr), 64'(last.wa));
      chk("sb_din", din, last.d);
      chk("sb_rd_adr", 64'(rd_adr), 64'(last.ra));
      chk("sb_fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
      chk("sb_cl_rdy", 64'(cl_rdy), 64'(q.size() < FD));
      chk("sb_oor_cnt", 64'(oor_cnt), 64'(oor_m));
      chk("sb_wcol_cnt", 64'(wcol_cnt), 64'(wcol_m));
    end
  end

  function automatic bundle_t mk(input logic [1:0] w, input int wa0, input int wa1,
                                 input logic [W-1:0] d0, input logic [W-1:0] d1,
                                 input logic [NR-1:0] r, input int ra0, input int ra1);
    bundle_t b;
    b.w  = w;
    b.wa = {BA'(wa1), BA'(wa0)};
    b.d  = {d1, d0};
    b.r  = r;
    b.ra = {BA'(ra1), BA'(ra0)};
    return b;
  endfunction

  function automatic int radr();
    case ($urandom_range(0, 3))
      0:       return 100;
      1:       return 101;
      2:       return 8190 + int'($urandom_range(0, 3));
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  function automatic bundle_t rnd_bundle();
    return mk(2'($urandom_range(0, 3)), radr(), radr(), $urandom, $urandom,
              2'($urandom_range(0, 3)), radr(), radr());
  endfunction

  task automatic drive(input bundle_t b);
    {cl_write, cl_wr_adr, cl_din, cl_read, cl_rd_adr} = b;
    cl_vld = 1'b1;
  endtask

  // Present a bundle and hold it until accepted (bounded); returns just after the accepting edge.
  task automatic push(input bundle_t b);
    bit got;
    @(negedge clk);
    drive(b);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      got = cl_rdy;
      @(posedge clk);
      if (got) break;
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cl_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write"}, 64'(write), 64'd0);
    chk({tag, "_read"}, 64'(read), 64'd0);
    chk({tag, "_wr_adr"}, 64'(wr_adr), 64'd0);
    chk({tag, "_din"}, din, 64'd0);
    chk({tag, "_rd_adr"}, 64'(rd_adr), 64'd0);
    chk({tag, "_fifo_cnt"}, 64'(fifo_cnt), 64'd0);
    chk({tag, "_oor_cnt"}, 64'(oor_cnt), 64'd0);
    chk({tag, "_wcol_cnt"}, 64'(wcol_cnt), 64'd0);
    chk({tag, "_cl_rdy"}, 64'(cl_rdy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    ready = 1'b1;
    cl_vld = 1'b0;
    cl_write = '0;
    cl_wr_adr = '0;
    cl_din = '0;
    cl_read = '0;
    cl_rd_adr = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Single write: visible for the one cycle after the edge following acceptance
    push(mk(2'b01, 5, 0, 32'hA5A5A5A5, 32'h0, 2'b00, 0, 0));
    idle();
    @(negedge clk);
    chk("t1_write", 64'(write), 64'd1);
    chk("t1_wr_adr0", 64'(wr_adr[BA-1:0]), 64'd5);
    chk("t1_din0", 64'(din[W-1:0]), 64'hA5A5A5A5);
    chk("t1_fifo_cnt", 64'(fifo_cnt), 64'd0);
    @(negedge clk);
    chk("t1_write_idle", 64'(write), 64'd0);

    // Fill with core not ready, then drain in order
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(2'b10, 0, 10 + i, 32'h0, 32'(i), 2'b01, 20 + i, 0));
    @(negedge clk);
    drive(mk(2'b10, 0, 14, 32'h0, 32'd4, 2'b01, 24, 0));
    @(negedge clk);
    chk("t2_fifo_full", 64'(fifo_cnt), 64'd4);
    chk("t2_cl_rdy_low", 64'(cl_rdy), 64'd0);
    ready = 1'b1;
    @(negedge clk);
    chk("t2_cl_rdy_back", 64'(cl_rdy), 64'd1);
    chk("t2_fifo_after_pop", 64'(fifo_cnt), 64'd3);
    idle();
    repeat (8) @(negedge clk);

    // Same-address double write: port 1 wins
    do_reset();
    push(mk(2'b11, 100, 100, 32'h55, 32'h1, 2'b00, 0, 0));
    idle();
    @(negedge clk);
    chk("t3_write", 64'(write), 64'd2);
    chk("t3_din1", 64'(din[2*W-1:W]), 64'd1);
    repeat (2) @(negedge clk);
    chk("t3_wcol_cnt", 64'(wcol_cnt), 64'd1);
    chk("t3_oor_cnt", 64'(oor_cnt), 64'd0);

    // Read range boundary
    do_reset();
    push(mk(2'b00, 0, 0, 32'h0, 32'h0, 2'b11, 8191, 8192));
    idle();
    @(negedge clk);
    chk("t4_read", 64'(read), 64'd1);
    repeat (2) @(negedge clk);
    chk("t4_oor_cnt", 64'(oor_cnt), 64'd1);
    chk("t4_wcol_cnt", 64'(wcol_cnt), 64'd0);

    // Random traffic with random core readiness
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) drive(rnd_bundle());
      else cl_vld = 1'b0;
    end
    idle();
    ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("rnd_drained", 64'(fifo_cnt), 64'd0);

    // Steady state at two entries, then asynchronous reset mid-stream
    do_reset();
    ready = 1'b0;
    push(rnd_bundle());
    push(rnd_bundle());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ready = 1'b1;
      drive(rnd_bundle());
      chk("t5_fifo_steady", 64'(fifo_cnt), 64'd2);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    cl_vld = 1'b0;
    #1;
    chk_all_zero("t5_async");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_stale_write", 64'(write), 64'd0);
      chk("t5_no_stale_read", 64'(read), 64'd0);
      chk("t5_fifo_empty", 64'(fifo_cnt), 64'd0);
    end

    // Saturate the out-of-range counter (4 drops per bundle)
    do_reset();
    for (int i = 0; i < 16500; i++) begin
      @(negedge clk);
      drive(mk(2'b11, NA + int'($urandom_range(0, 8191)), NA + int'($urandom_range(0, 8191)),
               $urandom, $urandom, 2'b11, NA + int'($urandom_range(0, 8191)),
               NA + int'($urandom_range(0, 8191))));
    end
    idle();
    repeat (3) @(negedge clk);
    chk("t6_oor_sat", 64'(oor_cnt), 64'hFFFF);
    chk("t6_wcol_zero", 64'(wcol_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
